// File: rtl/rotate_scheduler_if.sv
// Handshake bundle between two rotate requesters, the shared scheduler and
// the single result consumer.
interface rotate_scheduler_if #(
    parameter int REP_W = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_data;
    logic [4:0]       req0_amt;
    logic             req0_dir;
    logic [REP_W-1:0] req0_rep;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_data;
    logic [4:0]       req1_amt;
    logic             req1_dir;
    logic [REP_W-1:0] req1_rep;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_id;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_dir, req0_rep,
        output req1_valid, req1_data, req1_amt, req1_dir, req1_rep,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_dir, req0_rep,
        input  req1_valid, req1_data, req1_amt, req1_dir, req1_rep,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_id
    );
endinterface

// File: rtl/rotate_scheduler.sv
// Two requesters share one 32-bit circular rotator; a job rotates its word
// rep+1 times and the result is held until the consumer takes it.
module rotate_scheduler #(
    parameter int REP_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    rotate_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic [31:0]      data_q, data_d;
    logic [4:0]       amt_q, amt_d;
    logic             dir_q, dir_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             id_q, id_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_id_q, out_id_d;

    logic             any_valid;
    logic             grant_id;
    logic             req0_ready;
    logic             req1_ready;

    logic [31:0]      sel_data;
    logic [4:0]       sel_amt;
    logic             sel_dir;
    logic [REP_W-1:0] sel_rep;

    logic [63:0]      rot_double;
    logic [63:0]      rot_left;
    logic [63:0]      rot_right;
    logic [31:0]      rot_out;

    // Rotating the doubled word lets a plain shift wrap the bits around.
    always_comb begin
        rot_double = {data_q, data_q};
        rot_left   = rot_double << amt_q;
        rot_right  = rot_double >> amt_q;
        rot_out    = dir_q ? rot_left[63:32] : rot_right[31:0];
    end

    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = rr_q;
        end else begin
            grant_id = bus.req1_valid;
        end
        sel_data = grant_id ? bus.req1_data : bus.req0_data;
        sel_amt  = grant_id ? bus.req1_amt  : bus.req0_amt;
        sel_dir  = grant_id ? bus.req1_dir  : bus.req0_dir;
        sel_rep  = grant_id ? bus.req1_rep  : bus.req0_rep;
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        data_d     = data_q;
        amt_d      = amt_q;
        dir_d      = dir_q;
        rep_cnt_d  = rep_cnt_q;
        id_d       = id_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is gated by rst_n so it is low for the whole reset.
                if (rst_n && any_valid) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    data_d     = sel_data;
                    amt_d      = sel_amt;
                    dir_d      = sel_dir;
                    rep_cnt_d  = sel_rep;
                    id_d       = grant_id;
                    state_d    = ROT;
                end
            end
            ROT: begin
                data_d = rot_out;
                if (rep_cnt_q == '0) begin
                    out_data_d = rot_out;
                    out_id_d   = id_q;
                    state_d    = DONE;
                end else begin
                    rep_cnt_d = rep_cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    rr_d    = ~id_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            data_q     <= '0;
            amt_q      <= '0;
            dir_q      <= 1'b0;
            rep_cnt_q  <= '0;
            id_q       <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            data_q     <= data_d;
            amt_q      <= amt_d;
            dir_q      <= dir_d;
            rep_cnt_q  <= rep_cnt_d;
            id_q       <= id_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
        end
    end

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_data   = out_data_q;
    assign bus.out_id     = out_id_q;

endmodule

// File: tb/tb_rotate_scheduler.sv
// Directed and random jobs for rotate_scheduler, checked each cycle against a
// job-level model of arbitration, rotation results and output timing.
module tb_rotate_scheduler;

    localparam int REP_W = 3;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rotate_scheduler_if #(.REP_W(REP_W)) bus ();

    rotate_scheduler #(.REP_W(REP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: cycles of rotation still owed, whether a result is waiting,
    // round-robin owner and the visible output registers.
    int          m_rot_left;
    bit          m_done;
    bit          m_rr;
    logic [31:0] m_out_data;
    bit          m_out_id;
    logic [31:0] m_pend_data;
    bit          m_pend_id;

    function automatic logic [31:0] ref_rotate(logic [31:0] d, int n, bit left);
        if (n == 0) return d;
        if (left) return (d << n) | (d >> (32 - n));
        return (d >> n) | (d << (32 - n));
    endfunction

    function automatic logic [31:0] ref_job(logic [31:0] d, int n, bit left, int rep);
        logic [31:0] r;
        r = d;
        for (int i = 0; i <= rep; i++) r = ref_rotate(r, n, left);
        return r;
    endfunction

    task automatic compare(string tag, logic [31:0] obs, logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        bit idle, exp_r0, exp_r1;
        idle   = rst_n && !m_done && (m_rot_left == 0);
        exp_r0 = idle && bus.req0_valid && (!bus.req1_valid || m_rr == 1'b0);
        exp_r1 = idle && bus.req1_valid && (!bus.req0_valid || m_rr == 1'b1);
        compare({tag, ".out_valid"},  32'(bus.out_valid),  32'(m_done));
        compare({tag, ".out_data"},   bus.out_data,        m_out_data);
        compare({tag, ".out_id"},     32'(bus.out_id),     32'(m_out_id));
        compare({tag, ".req0_ready"}, 32'(bus.req0_ready), 32'(exp_r0));
        compare({tag, ".req1_ready"}, 32'(bus.req1_ready), 32'(exp_r1));
    endtask

    task automatic applyStimulus(
        bit v0, logic [31:0] d0, logic [4:0] a0, bit dir0, logic [REP_W-1:0] rep0,
        bit v1, logic [31:0] d1, logic [4:0] a1, bit dir1, logic [REP_W-1:0] rep1,
        bit ordy);
        bus.req0_valid = v0; bus.req0_data = d0; bus.req0_amt = a0;
        bus.req0_dir = dir0; bus.req0_rep = rep0;
        bus.req1_valid = v1; bus.req1_data = d1; bus.req1_amt = a1;
        bus.req1_dir = dir1; bus.req1_rep = rep1;
        bus.out_ready = ordy;
    endtask

    task automatic idleInputs(bit ordy);
        applyStimulus(0, 32'h0, 5'd0, 0, '0, 0, 32'h0, 5'd0, 0, '0, ordy);
    endtask

    // Advances the model by one rising edge using the inputs the DUT saw.
    task automatic modelEdge();
        bit sel;
        if (!rst_n) return;
        if (m_done) begin
            if (bus.out_ready) begin
                m_done = 0;
                m_rr   = !m_out_id;
            end
        end else if (m_rot_left > 0) begin
            m_rot_left--;
            if (m_rot_left == 0) begin
                m_done     = 1;
                m_out_data = m_pend_data;
                m_out_id   = m_pend_id;
            end
        end else if (bus.req0_valid || bus.req1_valid) begin
            sel = (bus.req0_valid && bus.req1_valid) ? m_rr : bus.req1_valid;
            m_pend_id = sel;
            if (sel) begin
                m_pend_data = ref_job(bus.req1_data, int'(bus.req1_amt), bus.req1_dir, int'(bus.req1_rep));
                m_rot_left  = int'(bus.req1_rep) + 1;
            end else begin
                m_pend_data = ref_job(bus.req0_data, int'(bus.req0_amt), bus.req0_dir, int'(bus.req0_rep));
                m_rot_left  = int'(bus.req0_rep) + 1;
            end
        end
    endtask

    task automatic cycle(string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        m_rot_left = 0; m_done = 0; m_rr = 0;
        m_out_data = '0; m_out_id = 0;
        checkOutput("reset");
        @(posedge clk);
        #1;
        checkOutput("reset_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        idleInputs(1);
        rst_n = 1'b1;
        #2;
        doReset();

        // Single left rotate on requester 0.
        applyStimulus(1, 32'h18A00000, 5'd10, 1, 3'd0, 0, 32'h0, 5'd0, 0, 3'd0, 1);
        cycle("r30_accept");
        idleInputs(1);
        cycle("r30_rot");
        compare("r30_valid", 32'(bus.out_valid), 32'd1);
        compare("r30_data",  bus.out_data, 32'h80000062);
        compare("r30_id",    32'(bus.out_id), 32'd0);
        cycle("r30_done");

        // Right rotate on requester 1 alone.
        applyStimulus(0, 32'h0, 5'd0, 0, 3'd0, 1, 32'h00FF0003, 5'd20, 0, 3'd0, 1);
        cycle("r31_accept");
        idleInputs(1);
        cycle("r31_rot");
        compare("r31_data", bus.out_data, 32'hF000300F);
        compare("r31_id",   32'(bus.out_id), 32'd1);
        cycle("r31_done");

        // Four passes of a one-bit left rotate.
        applyStimulus(1, 32'h00000001, 5'd1, 1, 3'd3, 0, 32'h0, 5'd0, 0, 3'd0, 1);
        cycle("r32_accept");
        idleInputs(1);
        for (int i = 0; i < 4; i++) cycle("r32_rot");
        compare("r32_data", bus.out_data, 32'h00000010);
        cycle("r32_done");

        // Consumer stalls for five cycles while both requesters keep offering.
        applyStimulus(1, 32'hCAFEF00D, 5'd7, 0, 3'd1, 1, 32'h12345678, 5'd31, 1, 3'd2, 0);
        for (int i = 0; i < 8; i++) cycle("r34_stall");
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle("r34_resume");

        // Reset in the middle of a long job, then a clean job.
        idleInputs(1);
        cycle("r35_gap");
        cycle("r35_gap");
        applyStimulus(1, 32'hA5A5A5A5, 5'd3, 1, 3'd7, 0, 32'h0, 5'd0, 0, 3'd0, 1);
        cycle("r35_accept");
        idleInputs(1);
        for (int i = 0; i < 3; i++) cycle("r35_rot");
        doReset();
        for (int i = 0; i < 10; i++) cycle("r35_after_reset");
        applyStimulus(0, 32'h0, 5'd0, 0, 3'd0, 1, 32'h0F0F0001, 5'd4, 0, 3'd2, 1);
        cycle("r35_new_accept");
        idleInputs(1);
        for (int i = 0; i < 4; i++) cycle("r35_new");

        // Both requesters saturated right after reset: strict alternation.
        doReset();
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1, 32'h1000 + 32'(i), 5'(i), i[0], 3'(i % 3),
                          1, 32'h2000 + 32'(i), 5'(31 - i), !i[0], 3'(i % 2), 1);
            cycle("r33_both");
        end

        // Random traffic with valid drops and consumer backpressure.
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 2) != 0, $urandom(), 5'($urandom()),
                          1'($urandom()), 3'($urandom()),
                          $urandom_range(0, 2) != 0, $urandom(), 5'($urandom()),
                          1'($urandom()), 3'($urandom()),
                          $urandom_range(0, 3) != 0);
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
